// File: rtl/clock_phase_sequencer_pkg.sv
// Shared types and the P/Q/R control-code table for the clock phase sequencer.
package lvdc_clk_pkg;

    // Computer clock phases, in sequencing order.
    typedef enum logic [1:0] {
        PH_W = 2'd0,
        PH_X = 2'd1,
        PH_Y = 2'd2,
        PH_Z = 2'd3
    } phase_t;

    // Sequencer control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP1 = 2'd2,
        ST_DRAIN = 2'd3
    } seq_state_t;

    // Control code per phase, bit order {P, Q, R}, indexed by phase_t.
    // P flips every phase; Q only moves when entering a P=1 phase (W/Y) and
    // R only when entering a P=0 phase (X/Z), so Q and R never move together.
    localparam logic [3:0][2:0] PQR_CODE = {
        3'b001,   // Z
        3'b100,   // Y
        3'b010,   // X
        3'b111    // W
    };

endpackage

// File: rtl/clock_phase_sequencer_phase_timer.sv
// Dwell counter and phase register; advances W->X->Y->Z while enabled and
// flags the last cycle of each phase and of each bit time.
module phase_timer
    import lvdc_clk_pkg::*;
#(
    parameter int PHASE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [1:0] phase,
    output logic [1:0] phase_nxt,
    output logic       phase_end,
    output logic       bit_end
);

    localparam int DW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(PHASE_CYCLES - 1);

    logic [DW-1:0] dwell_q, dwell_d;
    phase_t        phase_q, phase_d;

    // Count dwell cycles; at terminal count step to the next phase (Z wraps to W).
    always_comb begin
        phase_end = en && (dwell_q == DWELL_LAST);
        bit_end   = phase_end && (phase_q == PH_Z);
        dwell_d   = dwell_q;
        phase_d   = phase_q;
        if (phase_end) begin
            dwell_d = '0;
            phase_d = phase_t'(phase_q + 2'd1);
        end else if (en) begin
            dwell_d = dwell_q + 1'b1;
        end
    end

    // Counter registers; frozen while the sequencer is idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dwell_q <= '0;
            phase_q <= PH_W;
        end else begin
            dwell_q <= dwell_d;
            phase_q <= phase_d;
        end
    end

    assign phase     = phase_q;
    assign phase_nxt = phase_d;

endmodule

// File: rtl/clock_phase_sequencer.sv
// Run/halt/single-step sequencer driving the P/Q/R phase-control pairs and
// BOP enable for the clock drivers, plus the bit-time counter.
module clock_phase_sequencer
    import lvdc_clk_pkg::*;
#(
    parameter int PHASE_CYCLES = 4,
    parameter int BIT_TIMES    = 28
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         RUN,
    input  logic                         HALT_REQ,
    input  logic                         STEP,
    output logic                         BOP,
    output logic                         CGPP,
    output logic                         CGPPN,
    output logic                         CGQP,
    output logic                         CGQPN,
    output logic                         CGRP,
    output logic                         CGRPN,
    output logic [1:0]                   PHASE,
    output logic [$clog2(BIT_TIMES)-1:0] BIT_TIME,
    output logic                         WORD_END,
    output logic                         HALTED
);

    localparam int BTW = $clog2(BIT_TIMES);
    localparam logic [BTW-1:0] BT_LAST = BTW'(BIT_TIMES - 1);

    seq_state_t     state_q, state_d;
    logic           bop_q, bop_d;
    logic [2:0]     cg_q, cg_d;
    logic [BTW-1:0] bit_time_q, bit_time_d;

    logic           tmr_en;
    logic [1:0]     phase;
    logic [1:0]     phase_nxt;
    logic           phase_end;
    logic           bit_end;

    assign tmr_en = (state_q != ST_IDLE);

    phase_timer #(
        .PHASE_CYCLES(PHASE_CYCLES)
    ) u_phase_timer (
        .clk      (CLK),
        .rst_n    (RST_N),
        .en       (tmr_en),
        .phase    (phase),
        .phase_nxt(phase_nxt),
        .phase_end(phase_end),
        .bit_end  (bit_end)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST_N) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state: stops only on a bit-time boundary (Z->W); halt beats run/step.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (HALT_REQ)  state_d = ST_IDLE;
                else if (RUN)  state_d = ST_RUN;
                else if (STEP) state_d = ST_STEP1;
            end
            ST_RUN: begin
                // A stop request landing on the last cycle of a bit time halts
                // right there instead of draining a whole extra bit time.
                if (HALT_REQ || !RUN) state_d = bit_end ? ST_IDLE : ST_DRAIN;
            end
            ST_STEP1, ST_DRAIN: begin
                if (bit_end) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: BOP follows the next state; codes move only on phase boundaries.
    always_comb begin
        bop_d      = (state_d != ST_IDLE);
        cg_d       = phase_end ? PQR_CODE[phase_nxt] : cg_q;
        bit_time_d = bit_time_q;
        if (bit_end) bit_time_d = (bit_time_q == BT_LAST) ? '0 : bit_time_q + 1'b1;
    end

    // Registered output stage so the control lines are glitch-free.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            bop_q      <= 1'b0;
            cg_q       <= PQR_CODE[PH_W];
            bit_time_q <= '0;
        end else begin
            bop_q      <= bop_d;
            cg_q       <= cg_d;
            bit_time_q <= bit_time_d;
        end
    end

    assign BOP      = bop_q;
    assign CGPP     = cg_q[2];
    assign CGQP     = cg_q[1];
    assign CGRP     = cg_q[0];
    assign CGPPN    = ~cg_q[2];
    assign CGQPN    = ~cg_q[1];
    assign CGRPN    = ~cg_q[0];
    assign PHASE    = phase;
    assign BIT_TIME = bit_time_q;
    assign WORD_END = bit_end && (bit_time_q == BT_LAST);
    assign HALTED   = (state_q == ST_IDLE);

endmodule
